reg_cmd_sequencer: RTL and testbench
====================================

Name: reg_cmd_sequencer

Overview:
- Upstream control stage for the 4-bit register block (ports cl, ld, in, inc, dec, sr, ir, sl, il).
- Accepts opcode/operand/repeat-count commands over a valid/ready handshake.
- Expands each accepted command into a train of one-hot, one-cycle control strobes that drive the register directly.
- Reads the register output back (reg_q) to implement rotate-right, and signals completion with a done pulse.

Parameters:
- DATA_W, 4, width of operand, reg_d and reg_q; must match the register width.
- CNT_W, 4, width of the repeat-count field; a command issues cmd_cnt+1 strobes (1..2^CNT_W).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode: 0 NOP, 1 CLR, 2 LD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 ROR.
- cmd_data  input  DATA_W  LD operand; bit 0 is the fill bit for SHR/SHL.
- cmd_cnt  input  CNT_W  repeat count minus one (INC/DEC/SHR/SHL/ROR only).
- hold  input  1  stall; suppresses strobes and freezes progress while high.
- reg_q  input  DATA_W  current register output, fed back.
- reg_cl  output  1  clear strobe.
- reg_ld  output  1  load strobe.
- reg_d  output  DATA_W  load data.
- reg_inc  output  1  increment strobe.
- reg_dec  output  1  decrement strobe.
- reg_sr  output  1  shift-right strobe.
- reg_ir  output  1  shift-right fill bit.
- reg_sl  output  1  shift-left strobe.
- reg_il  output  1  shift-left fill bit.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last strobe of a command.

Behaviour:
- States: IDLE, EXEC, DONE. Registered: state, op_q, data_q, remaining counter rem_q (CNT_W bits).
- Reset (async, any state, including mid-command):
  - state=IDLE, op_q=0, data_q=0, rem_q=0.
  - Any in-flight command is dropped with no done pulse.
  - All strobes, reg_d, reg_ir, reg_il, busy and done read 0; cmd_ready=1 once rst_n is deasserted.
- Handshake:
  - cmd_ready = (state==IDLE), independent of cmd_valid (no combinational valid->ready path).
  - A command is accepted on the rising edge where cmd_valid && cmd_ready.
  - Inputs may change freely when not accepted.
- Accept transitions:
  - NOP accepted: IDLE->DONE; zero strobes issued.
  - CLR or LD accepted: IDLE->EXEC with rem_q=0; exactly one strobe, cmd_cnt ignored.
  - All other opcodes: IDLE->EXEC with rem_q=cmd_cnt.
- EXEC strobe decode:
  - Strobes are combinational from op_q and !hold; exactly one strobe is high per non-held EXEC cycle.
  - Strobe mapping: CLR->reg_cl, LD->reg_ld, INC->reg_inc, DEC->reg_dec, SHR/ROR->reg_sr, SHL->reg_sl.
  - reg_d = data_q whenever state==EXEC, else 0.
  - Fill bits:
    - SHR: reg_ir = data_q[0].
    - ROR: reg_ir = reg_q[0], re-sampled every strobe cycle from the live register output.
    - SHL: reg_il = data_q[0].
    - All other cases: fill bits are 0.
- EXEC progress:
  - On an edge with hold=1: state and rem_q unchanged.
  - On an edge with hold=0 and rem_q!=0: rem_q decrements.
  - On an edge with hold=0 and rem_q==0: EXEC->DONE.
- DONE: done=1 for one cycle, cmd_ready=0, then DONE->IDLE unconditionally (hold is ignored in DONE).
- Latency: accept at edge k; first strobe in cycle k+1; last strobe in cycle k+N (N = cmd_cnt+1, no hold); done in cycle k+N+1; cmd_ready high again in cycle k+N+2.
- Throughput: one command per N+2 cycles. Back-to-back cmd_valid is accepted in the first IDLE cycle.
- Boundary cases:
  - cmd_cnt = all-ones gives 2^CNT_W strobes; the counter does not wrap.
  - hold asserted in IDLE or DONE has no effect.
  - hold on the last strobe cycle delays done by the hold length.
- Opcode coverage: all 8 opcodes are legal; there are no error outputs.

Decomposition:
- Shared package reg_pkg holds:
  - opcode enum (OP_NOP..OP_ROR, 3 bits);
  - state enum (IDLE, EXEC, DONE);
  - localparam DATA_W=4.
- No sub-module: FSM, counter and strobe decode stay in one module.
- The top-level test harness instantiates reg_cmd_sequencer feeding the register block with reg_q looped back.

Test Plan:
1. LD data=4'hA, then INC cnt=2 -> one reg_ld with reg_d=A; then reg_inc high for 3 consecutive cycles; register reads 4'hD; done once after each command.
2. CLR from 4'hF with cnt=7 -> exactly one reg_cl cycle; register reads 0; done in the cycle after the strobe.
3. LD 4'b0001, then ROR cnt=3 -> reg_sr strobes with reg_ir sequence 1,0,0,0; register passes 1000,0100,0010,0001; ends at 4'b0001.
4. SHL data[0]=1 cnt=1 from 4'b0000 with hold high for 2 cycles after the first strobe -> strobes separated by 2 idle cycles; register 0001 then 0011; done delayed by 2 cycles.
5. DEC cnt=15 from 0 -> 16 reg_dec strobes; register wraps to 0; busy high for 17 cycles; cmd_ready low throughout.
6. rst_n asserted mid INC cnt=9 after 4 strobes -> strobes and busy drop immediately; no done pulse; cmd_ready=1 after release; NOP command then gives done with zero strobes.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared types for the 4-bit register block and its command sequencer.
package reg_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_CLR = 3'd1,
    OP_LD  = 3'd2,
    OP_INC = 3'd3,
    OP_DEC = 3'd4,
    OP_SHR = 3'd5,
    OP_SHL = 3'd6,
    OP_ROR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_cmd_sequencer.sv
// Expands opcode/operand/count commands into one-hot, one-cycle control
// strobes for the 4-bit register block, with a done pulse per command.
module reg_cmd_sequencer
  import reg_pkg::*;
#(
  parameter int DATA_W = reg_pkg::DATA_W,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              hold,
  input  logic [DATA_W-1:0] reg_q,
  output logic              reg_cl,
  output logic              reg_ld,
  output logic [DATA_W-1:0] reg_d,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic              reg_sr,
  output logic              reg_ir,
  output logic              reg_sl,
  output logic              reg_il,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                strobe_en;

  // Only the LSB of the register feeds back (rotate-right fill).
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q[DATA_W-1:1];

  // NOTE: async reset in the sensitivity list; all state uses non-blocking
  // assignments so every register samples its _d value from the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          data_d = cmd_data;
          unique case (op_e'(cmd_op))
            OP_NOP: begin
              state_d = DONE;
              rem_d   = '0;
            end
            OP_CLR, OP_LD: begin
              state_d = EXEC;
              rem_d   = '0;
            end
            default: begin
              state_d = EXEC;
              rem_d   = cmd_cnt;
            end
          endcase
        end
      end
      EXEC: begin
        if (!hold) begin
          if (rem_q == '0) state_d = DONE;
          else             rem_d   = rem_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign strobe_en = (state_q == EXEC) && !hold;

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    reg_d     = (state_q == EXEC) ? data_q : '0;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_sl    = 1'b0;
    reg_ir    = 1'b0;
    reg_il    = 1'b0;
    if (strobe_en) begin
      unique case (op_q)
        OP_CLR: reg_cl  = 1'b1;
        OP_LD:  reg_ld  = 1'b1;
        OP_INC: reg_inc = 1'b1;
        OP_DEC: reg_dec = 1'b1;
        OP_SHR: begin
          reg_sr = 1'b1;
          reg_ir = data_q[0];
        end
        // Rotate samples the live register LSB on every strobe.
        OP_ROR: begin
          reg_sr = 1'b1;
          reg_ir = reg_q[0];
        end
        OP_SHL: begin
          reg_sl = 1'b1;
          reg_il = data_q[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Scoreboard bench: the sequencer drives a behavioural 4-bit register whose
// output loops back; every busy/strobe/done cycle is matched against a queue.
module tb_reg_cmd_sequencer;
  import reg_pkg::*;

  typedef struct packed {
    logic       busy, ready, done;
    logic       cl, ld, inc, dec, sr, sl;
    logic       ir, il;
    logic [3:0] d;
  } obs_t;

  localparam logic [5:0] S_CL  = 6'b100000;
  localparam logic [5:0] S_LD  = 6'b010000;
  localparam logic [5:0] S_INC = 6'b001000;
  localparam logic [5:0] S_DEC = 6'b000100;
  localparam logic [5:0] S_SR  = 6'b000010;
  localparam logic [5:0] S_SL  = 6'b000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] cmd_cnt = 4'd0;
  logic       hold = 1'b0;
  logic [3:0] reg_q = 4'd0;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [3:0] reg_d;
  logic       busy, done;

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];
  obs_t act;

  reg_cmd_sequencer #(.DATA_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .hold(hold), .reg_q(reg_q),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_d(reg_d),
    .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register block model; not reset by the sequencer's reset.
  always @(posedge clk) begin
    if      (reg_cl)  reg_q <= 4'd0;
    else if (reg_ld)  reg_q <= reg_d;
    else if (reg_inc) reg_q <= reg_q + 4'd1;
    else if (reg_dec) reg_q <= reg_q - 4'd1;
    else if (reg_sr)  reg_q <= {reg_ir, reg_q[3:1]};
    else if (reg_sl)  reg_q <= {reg_q[2:0], reg_il};
  end

  assign act = '{busy: busy, ready: cmd_ready, done: done,
                 cl: reg_cl, ld: reg_ld, inc: reg_inc, dec: reg_dec,
                 sr: reg_sr, sl: reg_sl, ir: reg_ir, il: reg_il, d: reg_d};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic exp_s(input logic [5:0] stb, input logic ir, input logic il, input logic [3:0] d);
    obs_t o;
    o = '{busy: 1'b1, ready: 1'b0, done: 1'b0,
          cl: stb[5], ld: stb[4], inc: stb[3], dec: stb[2], sr: stb[1], sl: stb[0],
          ir: ir, il: il, d: d};
    exp_q.push_back(o);
  endtask

  task automatic exp_done();
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    exp_q.push_back(o);
  endtask

  // Monitor: every cycle with activity must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && (busy || done || reg_cl || reg_ld || reg_inc || reg_dec || reg_sr || reg_sl)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(act), 32'h0);
      end else begin
        check("event", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input op_e op, input logic [3:0] d, input logic [3:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_cnt   = c;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_cnt   = 4'd0;
  endtask

  task automatic wait_done(input string name, input logic [3:0] want_q);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!done) check({name, "_done_timeout"}, 32'(done), 32'd1);
    #1;
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    check({name, "_reg_q"}, 32'(reg_q), 32'(want_q));
  endtask

  initial begin
    #2;
    check("reset_outputs", 32'({act.busy, act.done, act.cl, act.ld, act.inc, act.dec,
                                act.sr, act.sl, act.ir, act.il, act.d}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // 1: load A then increment three times.
    exp_s(S_LD, 1'b0, 1'b0, 4'hA); exp_done();
    send(OP_LD, 4'hA, 4'd5);
    wait_done("ld_a", 4'hA);
    for (int i = 0; i < 3; i++) exp_s(S_INC, 1'b0, 1'b0, 4'h0);
    exp_done();
    send(OP_INC, 4'h0, 4'd2);
    wait_done("inc3", 4'hD);

    // 2: clear ignores the count.
    exp_s(S_LD, 1'b0, 1'b0, 4'hF); exp_done();
    send(OP_LD, 4'hF, 4'd0);
    wait_done("ld_f", 4'hF);
    exp_s(S_CL, 1'b0, 1'b0, 4'h0); exp_done();
    send(OP_CLR, 4'h0, 4'd7);
    wait_done("clr", 4'h0);

    // 3: rotate right four times, fill taken from the live LSB.
    exp_s(S_LD, 1'b0, 1'b0, 4'h1); exp_done();
    send(OP_LD, 4'h1, 4'd0);
    wait_done("ld_1", 4'h1);
    exp_s(S_SR, 1'b1, 1'b0, 4'h0);
    exp_s(S_SR, 1'b0, 1'b0, 4'h0);
    exp_s(S_SR, 1'b0, 1'b0, 4'h0);
    exp_s(S_SR, 1'b0, 1'b0, 4'h0);
    exp_done();
    send(OP_ROR, 4'h0, 4'd3);
    wait_done("ror4", 4'h1);

    // 4: shift-left with two held cycles between the strobes.
    exp_s(S_CL, 1'b0, 1'b0, 4'h0); exp_done();
    send(OP_CLR, 4'h0, 4'd0);
    wait_done("clr2", 4'h0);
    exp_s(S_SL, 1'b0, 1'b1, 4'h1);
    exp_s(6'b0, 1'b0, 1'b0, 4'h1);
    exp_s(6'b0, 1'b0, 1'b0, 4'h1);
    exp_s(S_SL, 1'b0, 1'b1, 4'h1);
    exp_done();
    send(OP_SHL, 4'h1, 4'd1);
    @(posedge clk); #1;
    check("shl_first_strobe", 32'(reg_q), 32'h1);
    hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    hold = 1'b0;
    wait_done("shl_hold", 4'h3);

    // Shift right: fill is only bit 0 of the operand.
    exp_s(S_SR, 1'b0, 1'b0, 4'hE);
    exp_s(S_SR, 1'b0, 1'b0, 4'hE);
    exp_done();
    send(OP_SHR, 4'hE, 4'd1);
    wait_done("shr2", 4'h0);

    // 5: full-count decrement wraps the register back to zero.
    for (int i = 0; i < 16; i++) exp_s(S_DEC, 1'b0, 1'b0, 4'h0);
    exp_done();
    send(OP_DEC, 4'h0, 4'hF);
    wait_done("dec16", 4'h0);

    // 6: reset in the middle of a ten-strobe increment.
    for (int i = 0; i < 4; i++) exp_s(S_INC, 1'b0, 1'b0, 4'h0);
    send(OP_INC, 4'h0, 4'd9);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_quiet", 32'({busy, done, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_d}), 32'h0);
    check("mid_reset_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("reg_after_abort", 32'(reg_q), 32'h4);

    // NOP with hold high: hold has no effect outside EXEC.
    hold = 1'b1;
    exp_done();
    send(OP_NOP, 4'h0, 4'd3);
    wait_done("nop", 4'h4);
    hold = 1'b0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
